if_id_pipe: RTL and testbench

//   Parametrised IF->ID pipeline register with valid/ready handshake, 2-entry skid buffer,

---
 rtl/if_id_pipe.sv | 126 ++++++++++++
 tb/tb_if_id_pipe.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/if_id_pipe.sv
// if_id_pipe: IF->ID pipeline register with valid/ready handshake, 2-entry
// skid buffer, synchronous flush and a saturating stall-cycle counter.
// It moves {pc, inst} from fetch to decode at up to one beat per cycle.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   flush                 drop every held and incoming beat (redirect)
//   up_valid/up_ready     fetch-side handshake; up_ready comes from registers only
//   up_pc, up_inst        fetch payload, sampled only when a beat is accepted
//   dn_valid/dn_ready     decode-side handshake
//   dn_pc, dn_inst        decode payload; 0 / NOP_INST while dn_valid is low
//   stall_cnt             saturating count of cycles with dn_valid & ~dn_ready
module if_id_pipe #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [PC_W-1:0]   up_pc,
  input  logic [INST_W-1:0] up_inst,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [PC_W-1:0]   dn_pc,
  output logic [INST_W-1:0] dn_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [PC_W-1:0]   main_pc, main_pc_n, skid_pc, skid_pc_n;
  logic [INST_W-1:0] main_inst, main_inst_n, skid_inst, skid_inst_n;
  logic              up_accept, dn_accept;

  // Both handshake outputs decode the state register alone, so neither
  // ready nor valid has a combinational path from the other side.
  assign dn_valid  = (state != EMPTY);
  assign up_ready  = (state != FULL);
  assign dn_pc     = main_pc;
  assign dn_inst   = main_inst;
  assign up_accept = up_valid & up_ready;
  assign dn_accept = dn_valid & dn_ready;

  always_comb begin
    state_n     = state;
    main_pc_n   = main_pc;
    main_inst_n = main_inst;
    skid_pc_n   = skid_pc;
    skid_inst_n = skid_inst;
    if (flush) begin
      // A beat taken by decode this cycle is already consumed; anything
      // offered by fetch this cycle is simply not captured.
      state_n     = EMPTY;
      main_pc_n   = '0;
      main_inst_n = NOP_INST;
      skid_pc_n   = '0;
      skid_inst_n = NOP_INST;
    end else begin
      unique case (state)
        EMPTY: begin
          if (up_accept) begin
            state_n     = ONE;
            main_pc_n   = up_pc;
            main_inst_n = up_inst;
          end
        end
        ONE: begin
          if (up_accept && dn_accept) begin
            main_pc_n   = up_pc;
            main_inst_n = up_inst;
          end else if (dn_accept) begin
            state_n     = EMPTY;
            main_pc_n   = '0;
            main_inst_n = NOP_INST;
          end else if (up_accept) begin
            state_n     = FULL;
            skid_pc_n   = up_pc;
            skid_inst_n = up_inst;
          end
        end
        FULL: begin
          if (dn_accept) begin
            state_n     = ONE;
            main_pc_n   = skid_pc;
            main_inst_n = skid_inst;
          end
        end
        default: begin
          state_n     = EMPTY;
          main_pc_n   = '0;
          main_inst_n = NOP_INST;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_pc   <= '0;
      main_inst <= NOP_INST;
      skid_pc   <= '0;
      skid_inst <= NOP_INST;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      main_pc   <= main_pc_n;
      main_inst <= main_inst_n;
      skid_pc   <= skid_pc_n;
      skid_inst <= skid_inst_n;
      // Flush does not clear the counter; only reset does.
      if (dn_valid && !dn_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// tb_if_id_pipe: directed-vector bench for if_id_pipe (CNT_W=4 so that
// saturation is reachable). Inputs change 1ns after each rising edge and the
// registered outputs are compared at that same point.
module tb_if_id_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, up_valid, up_ready, dn_valid, dn_ready;
  logic [31:0] up_pc, up_inst, dn_pc, dn_inst;
  logic [3:0]  stall_cnt;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  if_id_pipe #(
    .PC_W    (32),
    .INST_W  (32),
    .NOP_INST(NOP),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .up_pc    (up_pc),
    .up_inst  (up_inst),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready),
    .dn_pc    (dn_pc),
    .dn_inst  (dn_inst),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    up_valid = v;
    up_pc    = pc;
    up_inst  = pc + 32'h1000;
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(dn_valid), 64'(1));
    check({tag, ".pc"},    64'(dn_pc),    64'(pc));
    check({tag, ".inst"},  64'(dn_inst),  64'(pc + 32'h1000));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"}, 64'(dn_valid), 64'(0));
    check({tag, ".pc"},    64'(dn_pc),    64'(0));
    check({tag, ".inst"},  64'(dn_inst),  64'(NOP));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dn_ready = 1'b1;
    offer(1'b1, 32'h100);
    #1;

    // Reset with a beat offered
    step(); step();
    expect_idle("rst");
    check("rst.up_ready", 64'(up_ready), 64'(1));
    check("rst.cnt", 64'(stall_cnt), 64'(0));
    rst = 1'b0; offer(1'b0, 32'h0);
    step();
    expect_idle("rst_release");

    // Streaming, dn_ready=1
    offer(1'b1, 32'h0); step(); expect_beat("stream0", 32'h0);
    offer(1'b1, 32'h4); step(); expect_beat("stream1", 32'h4);
    offer(1'b1, 32'h8); step(); expect_beat("stream2", 32'h8);
    offer(1'b0, 32'h0); step(); expect_idle("stream_end");

    // Skid fill and drain
    dn_ready = 1'b0;
    offer(1'b1, 32'h10); step();
    expect_beat("skid_a", 32'h10);
    check("skid_a.up_ready", 64'(up_ready), 64'(1));
    offer(1'b1, 32'h14); step();
    expect_beat("skid_b", 32'h10);
    check("skid_b.up_ready", 64'(up_ready), 64'(0));
    offer(1'b0, 32'h0); step();
    expect_beat("skid_hold", 32'h10);
    check("skid_hold.cnt", 64'(stall_cnt), 64'(2));
    dn_ready = 1'b1; step();
    expect_beat("skid_drain", 32'h14);
    check("skid_drain.up_ready", 64'(up_ready), 64'(1));
    step();
    expect_idle("skid_empty");

    // Flush while FULL, with a beat offered in the flush cycle
    dn_ready = 1'b0;
    offer(1'b1, 32'h20); step();
    offer(1'b1, 32'h24); step();
    check("fl_full.up_ready", 64'(up_ready), 64'(0));
    flush = 1'b1; offer(1'b1, 32'h28); step();
    expect_idle("flush");
    check("flush.up_ready", 64'(up_ready), 64'(1));
    check("flush.cnt", 64'(stall_cnt), 64'(4));
    flush = 1'b0; offer(1'b0, 32'h0); dn_ready = 1'b1; step();
    expect_idle("flush_after");

    // Simultaneous accept in ONE
    offer(1'b1, 32'h30); step(); expect_beat("sim_a", 32'h30);
    offer(1'b1, 32'h34); step(); expect_beat("sim_b", 32'h34);
    check("sim_b.up_ready", 64'(up_ready), 64'(1));
    offer(1'b0, 32'h0); step(); expect_idle("sim_end");

    // Stall counter saturation, flush keeps it, reset clears it
    dn_ready = 1'b0;
    offer(1'b1, 32'h40); step();
    offer(1'b0, 32'h0);
    for (int i = 0; i < 20; i++) step();
    expect_beat("sat_hold", 32'h40);
    check("sat.cnt", 64'(stall_cnt), 64'(15));
    flush = 1'b1; step(); flush = 1'b0;
    expect_idle("sat_flush");
    check("sat_flush.cnt", 64'(stall_cnt), 64'(15));
    rst = 1'b1; step(); rst = 1'b0;
    check("sat_rst.cnt", 64'(stall_cnt), 64'(0));

    // Reset while FULL loses both entries
    offer(1'b1, 32'h50); step();
    offer(1'b1, 32'h54); step();
    check("mid_full.up_ready", 64'(up_ready), 64'(0));
    rst = 1'b1; offer(1'b0, 32'h0); step();
    expect_idle("mid_rst");
    check("mid_rst.up_ready", 64'(up_ready), 64'(1));
    rst = 1'b0; dn_ready = 1'b1; step();
    expect_idle("mid_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
